// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the sram-like request arbiter: requester IDs, grant FSM
// states and the default outstanding-request depth.
package sram_req_arbiter_pkg;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_id_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    localparam int DEFAULT_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/sram_req_arbiter_fifo.sv
// In-order FIFO of requester IDs for accepted but unanswered requests.
// The response path reads its head to route each data_ok.
module req_order_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_MAX_OUTSTANDING,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  req_id_e       id_in,
    output req_id_e       id_head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    req_id_e       id_mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign id_head = id_mem[rptr];

    // NOTE: the storage array is left unreset; occupancy is tracked by count
    // and the pointers, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            id_mem[wptr] <= id_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates instruction and data sram-like ports onto one downstream port
// with fixed data priority, grant locking and in-order response routing.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic [3:0]  io_cnt,
    output logic        resp_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e    state;
    req_id_e       lock_id;
    req_id_e       grant;
    req_id_e       id_head;
    logic          granted_req;
    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant = data_req ? REQ_DATA : REQ_INST;
        if (state == ST_LOCK) grant = lock_id;
    end

    always_comb begin
        granted_req = inst_req;
        mem_wr      = inst_wr;
        mem_size    = inst_size;
        mem_wstrb   = inst_wstrb;
        mem_addr    = inst_addr;
        mem_wdata   = inst_wdata;
        if (grant == REQ_DATA) begin
            granted_req = data_req;
            mem_wr      = data_wr;
            mem_size    = data_size;
            mem_wstrb   = data_wstrb;
            mem_addr    = data_addr;
            mem_wdata   = data_wdata;
        end
    end

    // Gating on resetn keeps mem_req low for the whole reset window.
    assign mem_req      = resetn && granted_req && !fifo_full;
    assign accept       = mem_req && mem_addr_ok;
    assign inst_addr_ok = accept && (grant == REQ_INST);
    assign data_addr_ok = accept && (grant == REQ_DATA);

    assign pop          = mem_data_ok && !fifo_empty;
    assign inst_data_ok = pop && (id_head == REQ_INST);
    assign data_data_ok = pop && (id_head == REQ_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign io_cnt       = 4'(fifo_count);

    req_order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .pop     (pop),
        .id_in   (grant),
        .id_head (id_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            lock_id  <= REQ_INST;
            resp_err <= 1'b0;
        end else begin
            if (mem_data_ok && fifo_empty) resp_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (mem_req && !mem_addr_ok) begin
                        state   <= ST_LOCK;
                        lock_id <= grant;
                    end
                end
                ST_LOCK: begin
                    if (accept) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a table of per-cycle vectors plus
// hand-written reset sequences.
module tb_sram_req_arbiter;

    localparam logic [31:0] IADDR  = 32'h1000_0040;
    localparam logic [31:0] DADDR  = 32'h2000_0080;
    localparam logic [31:0] IWDATA = 32'h0000_1111;
    localparam logic [31:0] DWDATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  io_cnt;
    logic        resp_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .io_cnt       (io_cnt),
        .resp_err     (resp_err)
    );

    typedef struct {
        logic       i_req;
        logic       d_req;
        logic       aok;
        logic       dok;
        logic       e_mreq;
        logic       e_gd;
        logic       e_iaok;
        logic       e_daok;
        logic       e_idok;
        logic       e_ddok;
        logic [3:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic i, d, a, o, mr, gd, ia, da, io, dd,
                                input logic [3:0] cnt, input logic err);
        vec_t v;
        v.i_req = i;  v.d_req = d;   v.aok = a;     v.dok = o;
        v.e_mreq = mr; v.e_gd = gd;  v.e_iaok = ia; v.e_daok = da;
        v.e_idok = io; v.e_ddok = dd; v.e_cnt = cnt; v.e_err = err;
        return v;
    endfunction

    task automatic drive(input logic i, d, a, o);
        inst_req    = i;
        data_req    = d;
        mem_addr_ok = a;
        mem_data_ok = o;
    endtask

    initial begin
        // columns: inst_req data_req addr_ok data_ok | mem_req grant_data
        //          iaok daok idok ddok io_cnt resp_err (all before the edge)
        vq.push_back(mk(1,1,1,0, 1,1, 0,1, 0,0, 4'd0, 0)); // both req: data wins
        vq.push_back(mk(1,0,1,0, 1,0, 1,0, 0,0, 4'd1, 0));
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 0,1, 4'd2, 0)); // head is data
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 1,0, 4'd1, 0));
        vq.push_back(mk(0,1,0,0, 1,1, 0,0, 0,0, 4'd0, 0)); // data stalls -> lock
        vq.push_back(mk(1,1,0,0, 1,1, 0,0, 0,0, 4'd0, 0));
        vq.push_back(mk(1,1,0,0, 1,1, 0,0, 0,0, 4'd0, 0));
        vq.push_back(mk(1,1,1,0, 1,1, 0,1, 0,0, 4'd0, 0)); // accept -> idle
        vq.push_back(mk(1,0,0,0, 1,0, 0,0, 0,0, 4'd1, 0)); // inst stalls -> lock
        vq.push_back(mk(1,1,1,0, 1,0, 1,0, 0,0, 4'd1, 0)); // lock beats priority
        vq.push_back(mk(0,1,1,1, 1,1, 0,1, 0,1, 4'd2, 0)); // push+pop together
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 1,0, 4'd2, 0));
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 0,1, 4'd1, 0));
        vq.push_back(mk(1,0,1,0, 1,0, 1,0, 0,0, 4'd0, 0)); // order i,d,i
        vq.push_back(mk(0,1,1,0, 1,1, 0,1, 0,0, 4'd1, 0));
        vq.push_back(mk(1,0,1,0, 1,0, 1,0, 0,0, 4'd2, 0));
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 1,0, 4'd3, 0));
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 0,1, 4'd2, 0));
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 1,0, 4'd1, 0));
        vq.push_back(mk(1,0,1,0, 1,0, 1,0, 0,0, 4'd0, 0)); // fill to 4
        vq.push_back(mk(0,1,1,0, 1,1, 0,1, 0,0, 4'd1, 0));
        vq.push_back(mk(1,0,1,0, 1,0, 1,0, 0,0, 4'd2, 0));
        vq.push_back(mk(0,1,1,0, 1,1, 0,1, 0,0, 4'd3, 0));
        vq.push_back(mk(0,1,1,0, 0,1, 0,0, 0,0, 4'd4, 0)); // full: held off
        vq.push_back(mk(0,1,1,1, 0,1, 0,0, 1,0, 4'd4, 0)); // pop, no bypass
        vq.push_back(mk(0,1,1,0, 1,1, 0,1, 0,0, 4'd3, 0)); // accept next cycle
        vq.push_back(mk(1,0,0,1, 0,0, 0,0, 0,1, 4'd4, 0));
        vq.push_back(mk(1,0,0,0, 1,0, 0,0, 0,0, 4'd3, 0));
        vq.push_back(mk(1,1,1,0, 1,0, 1,0, 0,0, 4'd3, 0));
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 1,0, 4'd4, 0)); // drain, pointers wrap
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 0,1, 4'd3, 0));
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 0,1, 4'd2, 0));
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 1,0, 4'd1, 0));
        vq.push_back(mk(0,0,0,1, 0,0, 0,0, 0,0, 4'd0, 0)); // stray response
        vq.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 4'd0, 1));

        inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF;
        inst_addr = IADDR; inst_wdata = IWDATA;
        data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'b0011;
        data_addr = DADDR; data_wdata = DWDATA;
        mem_rdata = 32'h0;
        resetn = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        #3;
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset data_addr_ok", 32'(data_addr_ok), 32'd0);
        check("reset io_cnt", 32'(io_cnt), 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;

        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k].i_req, vq[k].d_req, vq[k].aok, vq[k].dok);
            mem_rdata = 32'hA500_0000 | 32'(k);
            #2;
            check($sformatf("v%0d mem_req", k), 32'(mem_req), 32'(vq[k].e_mreq));
            check($sformatf("v%0d inst_addr_ok", k), 32'(inst_addr_ok), 32'(vq[k].e_iaok));
            check($sformatf("v%0d data_addr_ok", k), 32'(data_addr_ok), 32'(vq[k].e_daok));
            check($sformatf("v%0d inst_data_ok", k), 32'(inst_data_ok), 32'(vq[k].e_idok));
            check($sformatf("v%0d data_data_ok", k), 32'(data_data_ok), 32'(vq[k].e_ddok));
            check($sformatf("v%0d io_cnt", k), 32'(io_cnt), 32'(vq[k].e_cnt));
            check($sformatf("v%0d resp_err", k), 32'(resp_err), 32'(vq[k].e_err));
            check($sformatf("v%0d mem_addr", k), mem_addr, vq[k].e_gd ? DADDR : IADDR);
            check($sformatf("v%0d mem_wdata", k), mem_wdata, vq[k].e_gd ? DWDATA : IWDATA);
            check($sformatf("v%0d mem_wr", k), 32'(mem_wr), 32'(vq[k].e_gd));
            check($sformatf("v%0d inst_rdata", k), inst_rdata, 32'hA500_0000 | 32'(k));
            check($sformatf("v%0d data_rdata", k), data_rdata, 32'hA500_0000 | 32'(k));
        end

        // Two outstanding, data locked, then asynchronous reset mid-cycle.
        @(negedge clk); drive(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("pre-reset io_cnt", 32'(io_cnt), 32'd2);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async reset io_cnt", 32'(io_cnt), 32'd0);
        check("async reset mem_req", 32'(mem_req), 32'd0);
        check("async reset data_addr_ok", 32'(data_addr_ok), 32'd0);
        check("async reset resp_err", 32'(resp_err), 32'd0);

        // Late response after reset is not forwarded; lock was cleared.
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        check("post-reset inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("post-reset data_data_ok", 32'(data_data_ok), 32'd0);
        check("post-reset mem_addr", mem_addr, IADDR);
        check("post-reset mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("late resp resp_err", 32'(resp_err), 32'd1);
        check("late resp io_cnt", 32'(io_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter: MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests; power of two, 2..8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 inst_req / inst_wr / inst_size / inst_wstrb / inst_addr / inst_wdata  input  1/1/2/4/32/32  instruction-side sram-like request.
REQ-005 inst_addr_ok / inst_data_ok / inst_rdata  output  1/1/32  instruction-side accept, response and read data.
REQ-006 data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  input  1/1/2/4/32/32  data-side sram-like request.
REQ-007 data_addr_ok / data_data_ok / data_rdata  output  1/1/32  data-side accept, response and read data.
REQ-008 mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata  output  1/1/2/4/32/32  shared downstream request.
REQ-009 mem_addr_ok / mem_data_ok / mem_rdata  input  1/1/32  shared downstream accept, response and read data.
REQ-010 io_cnt  output  4  count of outstanding downstream requests.
REQ-011 resp_err  output  1  sticky flag; set when a response arrives with nothing outstanding.

Function
REQ-012 The FSM SHALL have two states: IDLE (grant free) and LOCK (grant held).
REQ-013 In IDLE, grant SHALL go to data when data_req=1, otherwise to inst; data has fixed priority.
REQ-014 mem_req SHALL equal the granted requester's req, gated low when io_cnt==MAX_OUTSTANDING; there is no same-cycle bypass from a pop.
REQ-015 mem_wr/size/wstrb/addr/wdata SHALL be a combinational mux of the granted requester's fields.
REQ-016 Accept is mem_req && mem_addr_ok; only the granted requester's addr_ok SHALL be 1, and it SHALL equal the accept.
REQ-017 Transitions: IDLE->LOCK when mem_req=1 and mem_addr_ok=0; LOCK->IDLE on accept. In LOCK the grant SHALL NOT change, even if the other requester asserts.
REQ-018 Each accept SHALL push the requester ID (0=inst, 1=data) into an in-order FIFO of depth MAX_OUTSTANDING.
REQ-019 When mem_data_ok=1 and the FIFO is non-empty, the FIFO SHALL pop and the head ID SHALL select which of inst_data_ok/data_data_ok is 1, in the same cycle.
REQ-020 inst_rdata and data_rdata SHALL both equal mem_rdata, passed through combinationally.
REQ-021 A simultaneous push and pop SHALL both take effect, leaving io_cnt unchanged.
REQ-022 io_cnt SHALL be +1 on push only, -1 on pop only, and equal to the FIFO occupancy.
REQ-023 Read and write pointers SHALL be log2(MAX_OUTSTANDING) bits and wrap modulo the depth.
REQ-024 mem_data_ok with an empty FIFO SHALL be ignored: no data_ok, no count change, resp_err set to 1 until reset.
REQ-025 A full FIFO SHALL hold mem_req=0 and all addr_ok=0; a held LOCK grant SHALL persist through the full condition.
REQ-026 The block SHALL add zero cycles of latency on both request and response paths.

Reset
REQ-027 On resetn=0, asynchronously: FSM=IDLE, pointers=0, io_cnt=0, resp_err=0.
REQ-028 Outputs in reset: mem_req=0, all addr_ok=0, all data_ok=0.
REQ-029 A reset mid-transaction SHALL discard all outstanding IDs; no late responses are forwarded after reset.

Structure
REQ-030 The shared package SHALL hold the requester ID encodings, the FSM state encoding and the default MAX_OUTSTANDING.
REQ-031 The order FIFO SHALL be a sub-module named req_order_fifo (push, pop, id_in, id_head, count, full, empty).
REQ-032 The grant FSM and request mux SHALL stay in sram_req_arbiter.

Verification
REQ-033 inst_req and data_req asserted together, mem_addr_ok=1 -> data granted first; data_addr_ok=1; io_cnt 0->1.
REQ-034 data_req with mem_addr_ok=0 for 3 cycles, inst_req raised in cycle 2 -> grant stays data (LOCK); on accept, data_addr_ok=1 and FSM returns to IDLE.
REQ-035 Accepts ordered inst, data, inst, then 3 mem_data_ok pulses -> inst_data_ok, data_data_ok, inst_data_ok in order; io_cnt 3->0.
REQ-036 4 accepts with no response -> io_cnt=4, mem_req=0; a mem_data_ok arrives while a request is pending -> pop this cycle, accept next cycle at the earliest.
REQ-037 mem_data_ok with io_cnt=0 -> no data_ok, resp_err=1 until resetn=0.
REQ-038 resetn pulled low with io_cnt=2 -> io_cnt=0, mem_req=0 immediately, without waiting for a clock edge.
